// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM encodings, register map indices, response codes.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_READY = 2'b10
  } apb_state_t;

  localparam int REG_ID      = 0;
  localparam int REG_STATUS  = 1;
  localparam int REG_RW_BASE = 2;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_slave_decoder.sv
// Combinational APB address decode: word index plus error flag (unaligned, out of range, RO write).
// Zero latency; no flow control of its own.
module apb_slave_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  output logic [ADDR_WIDTH-3:0] idx,
  output logic                  err
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  assign idx = paddr[ADDR_WIDTH-1:2];
  assign err = (paddr[1:0] != 2'b00)
            || (idx >= IDX_W'(NUM_REGS))
            || (pwrite && (idx < IDX_W'(REG_RW_BASE)));

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with ID/STATUS/RW register file; PREADY rises in access cycle WAIT_CYCLES+1.
// Dropping PSEL mid-transfer aborts to IDLE with no commit; back-to-back setups accepted.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 16,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE  = 32'hA2B0_0001
) (
  input  logic                             PCLK,
  input  logic                             PRST_n,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PWRITE,
  input  logic [ADDR_WIDTH-1:0]            PADDR,
  input  logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH-1:0]            PRDATA,
  output logic                             PREADY,
  output logic                             PSLVERR,
  input  logic [DATA_WIDTH-1:0]            STATUS_IN,
  output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] REG_OUT
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int NUM_RW = NUM_REGS - REG_RW_BASE;

  apb_state_t            state;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] setup_rdata;
  logic [3:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] rw_regs [NUM_RW];

  apb_slave_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_decoder (
    .paddr (PADDR),
    .pwrite(PWRITE),
    .idx   (dec_idx),
    .err   (dec_err)
  );

  always_comb begin
    rd_mux = '0;
    if (dec_idx == IDX_W'(REG_ID))
      rd_mux = ID_VALUE;
    else if (dec_idx == IDX_W'(REG_STATUS))
      rd_mux = STATUS_IN;
    for (int i = 0; i < NUM_RW; i++)
      if (dec_idx == IDX_W'(i + REG_RW_BASE))
        rd_mux = rw_regs[i];
  end

  // Read data (including STATUS_IN) is frozen at setup so wait states cannot change it.
  assign setup_rdata = (!PWRITE && !dec_err) ? rd_mux : '0;

  always_ff @(posedge PCLK or negedge PRST_n) begin
    if (!PRST_n) begin
      state    <= ST_IDLE;
      PREADY   <= 1'b0;
      PSLVERR  <= RESP_OKAY;
      PRDATA   <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
      for (int i = 0; i < NUM_RW; i++)
        rw_regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            idx_q    <= dec_idx;
            write_q  <= PWRITE;
            wdata_q  <= PWDATA;
            err_q    <= dec_err;
            rdata_q  <= setup_rdata;
            wait_cnt <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state   <= ST_READY;
              PREADY  <= 1'b1;
              PSLVERR <= dec_err ? RESP_SLVERR : RESP_OKAY;
              PRDATA  <= setup_rdata;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              state   <= ST_READY;
              PREADY  <= 1'b1;
              PSLVERR <= err_q ? RESP_SLVERR : RESP_OKAY;
              PRDATA  <= rdata_q;
            end
          end
        end
        ST_READY: begin
          // Leave on completion (PSEL&PENABLE) or abort (!PSEL); only completion commits.
          if (!PSEL || PENABLE) begin
            state   <= ST_IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= RESP_OKAY;
            PRDATA  <= '0;
            if (PSEL && write_q && !err_q)
              for (int i = 0; i < NUM_RW; i++)
                if (idx_q == IDX_W'(i + REG_RW_BASE))
                  rw_regs[i] <= wdata_q;
          end
        end
        default: begin
          state   <= ST_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= RESP_OKAY;
          PRDATA  <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
    assign REG_OUT[g*DATA_WIDTH +: DATA_WIDTH] = rw_regs[g];
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: three completers (WAIT_CYCLES 1, 0, 3) driven by a task-based APB requester.
module tb_apb_reg_slave;

  localparam int NDUT = 3;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int NR   = 8;
  localparam int ROW  = (NR - 2) * DW;

  logic clk;
  logic rst_n;

  logic            psel      [NDUT];
  logic            penable   [NDUT];
  logic            pwrite    [NDUT];
  logic [AW-1:0]   paddr     [NDUT];
  logic [DW-1:0]   pwdata    [NDUT];
  logic [DW-1:0]   prdata    [NDUT];
  logic            pready    [NDUT];
  logic            pslverr   [NDUT];
  logic [DW-1:0]   status_in [NDUT];
  logic [ROW-1:0]  reg_out   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    apb_reg_slave #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .WAIT_CYCLES(WC),
      .ID_VALUE   (32'hA2B0_0001)
    ) u_dut (
      .PCLK     (clk),
      .PRST_n   (rst_n),
      .PSEL     (psel[g]),
      .PENABLE  (penable[g]),
      .PWRITE   (pwrite[g]),
      .PADDR    (paddr[g]),
      .PWDATA   (pwdata[g]),
      .PRDATA   (prdata[g]),
      .PREADY   (pready[g]),
      .PSLVERR  (pslverr[g]),
      .STATUS_IN(status_in[g]),
      .REG_OUT  (reg_out[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [ROW-1:0] act, input logic [ROW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Full transfer from setup to the completing edge; returns #1 after that edge with PSEL still high.
  task automatic apb_xfer(input int d, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output logic er, output int n);
    bit done;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 0; done = 1'b0; rd = '0; er = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (pready[d]) begin
        rd = prdata[d];
        er = pslverr[d];
        done = 1'b1;
      end else begin
        chk("slverr_without_ready", ROW'(pslverr[d]), ROW'(0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic go_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;

  vec_t           vt [12];
  logic [DW-1:0]  model [NR-2];
  logic [ROW-1:0] exp_row;
  logic [DW-1:0]  rd;
  logic           er;
  int             n;
  int             k;

  function automatic logic [ROW-1:0] pack_model();
    logic [ROW-1:0] r;
    for (int i = 0; i < NR - 2; i++) r[i*DW +: DW] = model[i];
    return r;
  endfunction

  initial begin
    vt[0]  = '{1'b0, 16'h0000, 32'h0000_0000, 32'hA2B0_0001, 1'b0};
    vt[1]  = '{1'b1, 16'h0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vt[2]  = '{1'b0, 16'h0008, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vt[3]  = '{1'b1, 16'h0004, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vt[4]  = '{1'b0, 16'h0020, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[5]  = '{1'b0, 16'h0009, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[6]  = '{1'b1, 16'h0000, 32'h2222_2222, 32'h0000_0000, 1'b1};
    vt[7]  = '{1'b1, 16'h001C, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
    vt[8]  = '{1'b0, 16'h001C, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};
    vt[9]  = '{1'b0, 16'h0004, 32'h0000_0000, 32'hCAFE_0000, 1'b0};
    vt[10] = '{1'b1, 16'h000A, 32'h3333_3333, 32'h0000_0000, 1'b1};
    vt[11] = '{1'b0, 16'h0018, 32'h0000_0000, 32'h0000_0000, 1'b0};
    for (int i = 0; i < NR - 2; i++) model[i] = '0;

    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; status_in[d] = '0;
    end
    #2;
    chk("reset_pready", ROW'(pready[0]), ROW'(0));
    chk("reset_pslverr", ROW'(pslverr[0]), ROW'(0));
    chk("reset_prdata", ROW'(prdata[0]), ROW'(0));
    chk("reset_reg_out", reg_out[0], '0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table on the one-wait-state completer, transfers issued back to back.
    status_in[0] = 32'hCAFE_0000;
    for (int i = 0; i < 12; i++) begin
      apb_xfer(0, vt[i].wr, vt[i].addr, vt[i].wdata, rd, er, n);
      if (vt[i].wr && !vt[i].exp_err) begin
        k = int'(vt[i].addr[AW-1:2]) - 2;
        model[k] = vt[i].wdata;
      end
      chk($sformatf("v%0d_prdata", i), ROW'(rd), ROW'(vt[i].exp_rd));
      chk($sformatf("v%0d_pslverr", i), ROW'(er), ROW'(vt[i].exp_err));
      chk($sformatf("v%0d_access_cycles", i), ROW'(n), ROW'(2));
      chk($sformatf("v%0d_reg_out", i), reg_out[0], pack_model());
    end
    go_idle(0);
    @(posedge clk); #1;

    // Zero-wait build: back-to-back write/read to 0x000C.
    apb_xfer(1, 1'b1, 16'h000C, 32'h1111_2222, rd, er, n);
    chk("wc0_write_cycles", ROW'(n), ROW'(1));
    chk("wc0_write_err", ROW'(er), ROW'(0));
    apb_xfer(1, 1'b0, 16'h000C, 32'h0, rd, er, n);
    chk("wc0_read_cycles", ROW'(n), ROW'(1));
    chk("wc0_read_data", ROW'(rd), ROW'(32'h1111_2222));
    exp_row = '0; exp_row[63:32] = 32'h1111_2222;
    chk("wc0_reg_out", reg_out[1], exp_row);
    go_idle(1);

    // Three-wait build: same back-to-back pair.
    apb_xfer(2, 1'b1, 16'h000C, 32'h7777_8888, rd, er, n);
    chk("wc3_write_cycles", ROW'(n), ROW'(4));
    apb_xfer(2, 1'b0, 16'h000C, 32'h0, rd, er, n);
    chk("wc3_read_cycles", ROW'(n), ROW'(4));
    chk("wc3_read_data", ROW'(rd), ROW'(32'h7777_8888));
    go_idle(2);
    @(posedge clk); #1;

    // PENABLE without a setup cycle must be ignored.
    psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b0; paddr[1] = 16'h0000;
    @(negedge clk);
    chk("penable_idle_a", ROW'(pready[1]), ROW'(0));
    @(negedge clk);
    chk("penable_idle_b", ROW'(pready[1]), ROW'(0));
    @(posedge clk); #1;
    go_idle(1);

    // STATUS_IN is taken at setup even if it changes during the wait states.
    status_in[2] = 32'h1234_5678;
    fork
      apb_xfer(2, 1'b0, 16'h0004, 32'h0, rd, er, n);
      begin
        @(posedge clk); #2;
        status_in[2] = 32'h0;
      end
    join
    chk("status_sampled_data", ROW'(rd), ROW'(32'h1234_5678));
    chk("status_sampled_cycles", ROW'(n), ROW'(4));
    go_idle(2);
    @(posedge clk); #1;

    // Abort: PSEL dropped while waiting, write to 0x0014 must not commit.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 16'h0014; pwdata[0] = 32'hFFFF_0000;
    @(posedge clk); #1;
    go_idle(0);
    @(negedge clk);
    chk("abort_pready_a", ROW'(pready[0]), ROW'(0));
    @(negedge clk);
    chk("abort_pready_b", ROW'(pready[0]), ROW'(0));
    chk("abort_no_commit", reg_out[0], pack_model());
    @(posedge clk); #1;

    // Reset during WAIT of a write to 0x0010, then a clean transfer.
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 16'h0010; pwdata[2] = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_pready", ROW'(pready[2]), ROW'(0));
    chk("midreset_reg_out2", reg_out[2], '0);
    chk("midreset_reg_out0", reg_out[0], '0);
    go_idle(2);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(2, 1'b1, 16'h0010, 32'h0000_AB12, rd, er, n);
    chk("post_reset_cycles", ROW'(n), ROW'(4));
    chk("post_reset_err", ROW'(er), ROW'(0));
    exp_row = '0; exp_row[95:64] = 32'h0000_AB12;
    chk("post_reset_reg_out", reg_out[2], exp_row);
    go_idle(2);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
